// File: rtl/square_osc.sv
// square_osc: glitch-free square-wave oscillator.
// Counts system clocks to produce a square wave whose full cycle is `period`
// clocks. The high phase is floor(P/2) clocks and the low phase is ceil(P/2).
// A new period and note-off are only acted on at a waveform-cycle boundary,
// so the output never emits a truncated or malformed cycle.
module square_osc #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] period,
    input  logic             gate,
    output logic             wave_out,
    output logic             cycle_start,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] per_q;
    logic [WIDTH-1:0] cnt;

    logic             start_ok;
    logic             last_clk;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] half;

    // Periods 0 and 1 are treated as mute; a cycle needs at least one high
    // and one low clock.
    assign start_ok = gate && (period >= WIDTH'(2));

    // per_q is at least 2 whenever state is RUN, so per_q-1 never underflows
    // while this comparison matters.
    assign last_clk = (cnt == (per_q - WIDTH'(1)));
    assign cnt_inc  = cnt + WIDTH'(1);
    assign half     = per_q >> 1;

    assign busy = (state == RUN);

    // Oscillator state machine; wave_out is precomputed for the next count so
    // the output itself is a clean register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            per_q       <= '0;
            cnt         <= '0;
            wave_out    <= 1'b0;
            cycle_start <= 1'b0;
        end else begin
            cycle_start <= 1'b0;
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    wave_out <= 1'b0;
                    if (start_ok) begin
                        per_q       <= period;
                        wave_out    <= 1'b1;
                        cycle_start <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (!last_clk) begin
                        cnt      <= cnt_inc;
                        wave_out <= (cnt_inc < half);
                    end else if (start_ok) begin
                        per_q       <= period;
                        cnt         <= '0;
                        wave_out    <= 1'b1;
                        cycle_start <= 1'b1;
                    end else begin
                        cnt      <= '0;
                        wave_out <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    cnt      <= '0;
                    wave_out <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_square_osc.sv
// tb_square_osc: scoreboard bench for square_osc.
// A reference model expands each accepted waveform cycle into its complete
// list of output samples; a monitor compares the DUT against that list every
// clock. Directed scenarios are followed by randomized period/gate traffic.
module tb_square_osc;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] period;
    logic             gate;
    logic             wave_out;
    logic             cycle_start;
    logic             busy;

    // Expected sample encoding: {busy, cycle_start, wave_out}
    logic [2:0] pending[$];
    logic [2:0] exp_q[$];

    int n_pass;
    int n_total;
    int cyc;

    square_osc #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .period      (period),
        .gate        (gate),
        .wave_out    (wave_out),
        .cycle_start (cycle_start),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @cyc %0d: got busy/cs/wave=%b required %b", name, cyc, got, exp);
        end
    endtask

    // Reference model: one whole waveform cycle is queued as a list of samples
    // when it is accepted; when that list runs dry the next edge is a boundary.
    always @(posedge clk) begin
        int p;
        cyc++;
        if (!rst_n) begin
            pending.delete();
            exp_q.push_back(3'b000);
        end else begin
            if (pending.size() == 0 && gate && period >= 2) begin
                p = int'(period);
                for (int i = 0; i < p; i++) begin
                    pending.push_back({1'b1, (i == 0), (i < p / 2)});
                end
            end
            if (pending.size() != 0)
                exp_q.push_back(pending.pop_front());
            else
                exp_q.push_back(3'b000);
        end
    end

    // Monitor: every clock the DUT presents one sample; compare it away from
    // the active edge.
    always @(posedge clk) begin
        logic [2:0] e;
        #1;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard_empty @cyc %0d: got no expected sample, required one", cyc);
        end else begin
            e = exp_q.pop_front();
            check("out", {busy, cycle_start, wave_out}, e);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        gate    = 1'b0;
        period  = '0;
        #1;
        check("reset_state", {busy, cycle_start, wave_out}, 3'b000);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Basic tone
        period = 16'd4; gate = 1'b1;
        tick(12);
        gate = 1'b0;
        tick(6);

        // Odd period, then minimum period
        period = 16'd5; gate = 1'b1;
        tick(10);
        period = 16'd2;
        tick(8);
        gate = 1'b0;
        tick(4);

        // Mute periods with gate high
        period = 16'd1; gate = 1'b1;
        tick(5);
        period = 16'd0;
        tick(5);
        gate = 1'b0;
        tick(2);

        // Period change mid-cycle
        period = 16'd6; gate = 1'b1;
        tick(3);
        period = 16'd4;
        tick(14);
        gate = 1'b0;
        tick(6);

        // Note off mid-cycle
        period = 16'd8; gate = 1'b1;
        tick(4);
        gate = 1'b0;
        tick(12);

        // Gate pulse that recovers before the boundary
        period = 16'd6; gate = 1'b1;
        tick(2);
        gate = 1'b0;
        tick(2);
        gate = 1'b1;
        tick(10);

        // Period goes invalid while gated, then valid again
        period = 16'd1;
        tick(8);
        period = 16'd3;
        tick(7);
        gate = 1'b0;
        tick(4);

        // Async reset mid-cycle, half a clock after E5
        period = 16'd10; gate = 1'b1;
        tick(6);
        check("busy_before_reset", {busy, 2'b00}, 3'b100);
        rst_n = 1'b0;
        #1;
        check("async_reset", {busy, cycle_start, wave_out}, 3'b000);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        gate = 1'b0;
        tick(12);

        // Randomized period/gate traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                period = WIDTH'($urandom_range(0, 12));
            gate = ($urandom_range(0, 4) != 0);
            tick(1);
        end
        gate = 1'b0;
        tick(14);

        // Max period: one full cycle, then the recurring cycle_start
        period = 16'hFFFF; gate = 1'b1;
        tick(65540);
        rst_n = 1'b0;
        #1;
        check("async_reset_max", {busy, cycle_start, wave_out}, 3'b000);
        tick(2);
        gate  = 1'b0;
        rst_n = 1'b1;
        tick(4);

        if (exp_q.size() > 1) begin
            n_total++;
            $display("FAIL scoreboard_drain: got %0d leftover samples, required at most 1", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
